// File: rtl/ipv4_header_stripper.sv
// IPv4 header stripper: parses and validates the IPv4 header, forwards the UDP
// datagram of accepted packets through a single-entry output register.
module ipv4_header_stripper #(
  parameter int unsigned CHECK_CSUM = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ip_data_in,
  input  logic        ip_valid_in,
  output logic        ip_ready_out,
  output logic [7:0]  data_out,
  output logic        data_valid_out,
  output logic        data_last_out,
  input  logic        ready_in,
  output logic [31:0] src_ip,
  output logic [31:0] dst_ip,
  output logic [15:0] ip_total_length,
  output logic        hdr_valid,
  output logic        drop_pulse,
  output logic [15:0] drop_count
);

  typedef enum logic [1:0] {S_HDR, S_FWD, S_DROP} state_e;

  state_e      state_q, state_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]  ver_ihl_q, ver_ihl_d;
  logic [15:0] tot_len_q, tot_len_d;
  logic [7:0]  proto_q, proto_d;
  logic [31:0] src_cap_q, src_cap_d;
  logic [31:0] dst_cap_q, dst_cap_d;
  logic [15:0] csum_q, csum_d;
  logic [7:0]  csum_hi_q, csum_hi_d;
  logic [7:0]  data_q, data_d;
  logic        dv_q, dv_d;
  logic        last_q, last_d;
  logic [31:0] src_ip_q, src_ip_d;
  logic [31:0] dst_ip_q, dst_ip_d;
  logic [15:0] ip_tot_q, ip_tot_d;
  logic        hdr_valid_q, hdr_valid_d;
  logic        drop_pulse_q, drop_pulse_d;
  logic [15:0] drop_count_q, drop_count_d;

  logic        in_fire, out_fire, pkt_last, reject;
  logic [3:0]  ihl;
  logic [15:0] hdr_len, hdr_last, min_len;
  logic [16:0] csum_sum;
  logic [15:0] csum_next;

  assign ihl      = ver_ihl_q[3:0];
  // A short IHL still waits for the 20 fixed bytes so total_length is known before dropping.
  assign hdr_len  = (ihl < 4'd5) ? 16'd20 : {10'd0, ihl, 2'b00};
  assign hdr_last = hdr_len - 16'd1;
  assign min_len  = hdr_len + 16'd8;

  assign csum_sum  = {1'b0, csum_q} + {1'b0, csum_hi_q, ip_data_in};
  assign csum_next = csum_sum[15:0] + {15'd0, csum_sum[16]};

  assign reject = (ver_ihl_q[7:4] != 4'd4) || (ihl < 4'd5) || (tot_len_q < min_len) ||
                  (proto_q != 8'd17) || ((CHECK_CSUM != 0) && (csum_next != 16'hFFFF));

  assign ip_ready_out = (state_q != S_FWD) || !dv_q || ready_in;
  assign in_fire      = ip_valid_in && ip_ready_out;
  assign out_fire     = dv_q && ready_in;
  assign pkt_last     = (byte_cnt_q == tot_len_q - 16'd1);

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    ver_ihl_d    = ver_ihl_q;
    tot_len_d    = tot_len_q;
    proto_d      = proto_q;
    src_cap_d    = src_cap_q;
    dst_cap_d    = dst_cap_q;
    csum_d       = csum_q;
    csum_hi_d    = csum_hi_q;
    data_d       = data_q;
    dv_d         = dv_q;
    last_d       = last_q;
    src_ip_d     = src_ip_q;
    dst_ip_d     = dst_ip_q;
    ip_tot_d     = ip_tot_q;
    hdr_valid_d  = 1'b0;
    drop_pulse_d = 1'b0;
    drop_count_d = drop_count_q;

    if (out_fire) dv_d = 1'b0;

    if (in_fire) begin
      byte_cnt_d = byte_cnt_q + 16'd1;
      unique case (state_q)
        S_HDR: begin
          if (byte_cnt_q == 16'd0) ver_ihl_d = ip_data_in;
          if (byte_cnt_q == 16'd2) tot_len_d = {ip_data_in, tot_len_q[7:0]};
          if (byte_cnt_q == 16'd3) tot_len_d = {tot_len_q[15:8], ip_data_in};
          if (byte_cnt_q == 16'd9) proto_d = ip_data_in;
          if (byte_cnt_q >= 16'd12 && byte_cnt_q <= 16'd15) src_cap_d = {src_cap_q[23:0], ip_data_in};
          if (byte_cnt_q >= 16'd16 && byte_cnt_q <= 16'd19) dst_cap_d = {dst_cap_q[23:0], ip_data_in};

          if (byte_cnt_q == 16'd0) begin
            csum_d    = '0;
            csum_hi_d = ip_data_in;
          end else if (byte_cnt_q[0]) begin
            csum_d = csum_next;
          end else begin
            csum_hi_d = ip_data_in;
          end

          if (byte_cnt_q == hdr_last) begin
            if (reject) begin
              drop_pulse_d = 1'b1;
              if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
              // A length that ends inside the header leaves nothing further to consume.
              if (tot_len_q <= hdr_len) begin
                state_d    = S_HDR;
                byte_cnt_d = '0;
              end else begin
                state_d = S_DROP;
              end
            end else begin
              state_d     = S_FWD;
              src_ip_d    = src_cap_d;
              dst_ip_d    = dst_cap_d;
              ip_tot_d    = tot_len_q;
              hdr_valid_d = 1'b1;
            end
          end
        end
        S_FWD: begin
          data_d = ip_data_in;
          dv_d   = 1'b1;
          last_d = pkt_last;
          if (pkt_last) begin
            state_d    = S_HDR;
            byte_cnt_d = '0;
          end
        end
        S_DROP: begin
          if (pkt_last) begin
            state_d    = S_HDR;
            byte_cnt_d = '0;
          end
        end
        default: begin
          state_d    = S_HDR;
          byte_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_HDR;
      byte_cnt_q   <= '0;
      ver_ihl_q    <= '0;
      tot_len_q    <= '0;
      proto_q      <= '0;
      src_cap_q    <= '0;
      dst_cap_q    <= '0;
      csum_q       <= '0;
      csum_hi_q    <= '0;
      data_q       <= '0;
      dv_q         <= 1'b0;
      last_q       <= 1'b0;
      src_ip_q     <= '0;
      dst_ip_q     <= '0;
      ip_tot_q     <= '0;
      hdr_valid_q  <= 1'b0;
      drop_pulse_q <= 1'b0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      ver_ihl_q    <= ver_ihl_d;
      tot_len_q    <= tot_len_d;
      proto_q      <= proto_d;
      src_cap_q    <= src_cap_d;
      dst_cap_q    <= dst_cap_d;
      csum_q       <= csum_d;
      csum_hi_q    <= csum_hi_d;
      data_q       <= data_d;
      dv_q         <= dv_d;
      last_q       <= last_d;
      src_ip_q     <= src_ip_d;
      dst_ip_q     <= dst_ip_d;
      ip_tot_q     <= ip_tot_d;
      hdr_valid_q  <= hdr_valid_d;
      drop_pulse_q <= drop_pulse_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign data_out        = data_q;
  assign data_valid_out  = dv_q;
  assign data_last_out   = last_q;
  assign src_ip          = src_ip_q;
  assign dst_ip          = dst_ip_q;
  assign ip_total_length = ip_tot_q;
  assign hdr_valid       = hdr_valid_q;
  assign drop_pulse      = drop_pulse_q;
  assign drop_count      = drop_count_q;

endmodule

// File: tb/tb_ipv4_header_stripper.sv
// Randomized bench for ipv4_header_stripper: packets are built in the bench and the
// expected datagram bytes, drops and header fields come from a packet-level model.
module tb_ipv4_header_stripper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  ip_data_in;
  logic        ip_valid_in;
  logic        ip_ready_out;
  logic [7:0]  data_out;
  logic        data_valid_out, data_last_out, ready_in;
  logic [31:0] src_ip, dst_ip;
  logic [15:0] ip_total_length;
  logic        hdr_valid, drop_pulse;
  logic [15:0] drop_count;

  logic [7:0]  nc_data_in;
  logic        nc_valid_in, nc_ready_out;
  logic [7:0]  nc_data_out;
  logic        nc_dv, nc_last, nc_hv, nc_dp;
  logic [31:0] nc_src, nc_dst;
  logic [15:0] nc_tot, nc_dc;

  always #5 clk = ~clk;

  ipv4_header_stripper #(.CHECK_CSUM(1)) dut (
    .clk(clk), .rst_n(rst_n), .ip_data_in(ip_data_in), .ip_valid_in(ip_valid_in),
    .ip_ready_out(ip_ready_out), .data_out(data_out), .data_valid_out(data_valid_out),
    .data_last_out(data_last_out), .ready_in(ready_in), .src_ip(src_ip), .dst_ip(dst_ip),
    .ip_total_length(ip_total_length), .hdr_valid(hdr_valid), .drop_pulse(drop_pulse),
    .drop_count(drop_count)
  );

  ipv4_header_stripper #(.CHECK_CSUM(0)) dut_nc (
    .clk(clk), .rst_n(rst_n), .ip_data_in(nc_data_in), .ip_valid_in(nc_valid_in),
    .ip_ready_out(nc_ready_out), .data_out(nc_data_out), .data_valid_out(nc_dv),
    .data_last_out(nc_last), .ready_in(1'b1), .src_ip(nc_src), .dst_ip(nc_dst),
    .ip_total_length(nc_tot), .hdr_valid(nc_hv), .drop_pulse(nc_dp), .drop_count(nc_dc)
  );

  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  int ready_mode = 0;
  logic [7:0] pkt[$];
  logic [8:0] exp_q[$], rx_q[$], nc_exp_q[$], nc_rx_q[$];
  int exp_drops = 0;
  int hv_cnt = 0, dp_cnt = 0, nc_hv_cnt = 0, nc_dp_cnt = 0;
  int hv_cyc = 0, hdr_acc_cyc = 0;
  int bp_viol = 0, hold_viol = 0, overlap = 0;
  logic [31:0] exp_src = '0, exp_dst = '0;
  logic [15:0] exp_tot = '0;
  logic stall_prev = 1'b0;
  logic [8:0] held = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    ready_in = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (ready_mode == 1) ready_in = ~ready_in;
      else if (ready_mode == 2) ready_in = 1'($urandom_range(0, 1));
      else ready_in = 1'b1;
    end
  end

  // Observer: collects output beats and pulses; the test tasks judge them.
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1) begin
      if (stall_prev && {data_last_out, data_out} !== held) hold_viol++;
      if (data_valid_out && !data_last_out && !ready_in && ip_ready_out) bp_viol++;
      if (data_valid_out && data_last_out && ip_valid_in && ip_ready_out) overlap++;
      if (data_valid_out && ready_in) rx_q.push_back({data_last_out, data_out});
      if (hdr_valid) begin
        hv_cnt++;
        hv_cyc = cyc;
      end
      if (drop_pulse) dp_cnt++;
      if (nc_dv) nc_rx_q.push_back({nc_last, nc_data_out});
      if (nc_hv) nc_hv_cnt++;
      if (nc_dp) nc_dp_cnt++;
      stall_prev = data_valid_out && !ready_in;
      held = {data_last_out, data_out};
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t (required to finish earlier)", $time);
    $fatal(1);
  end

  task automatic build_pkt(input int ihl, input int plen, input logic [7:0] proto,
                           input logic [3:0] ver, input bit corrupt);
    int hl, tot;
    int unsigned sum;
    hl = ihl * 4;
    tot = hl + plen;
    pkt.delete();
    for (int i = 0; i < tot; i++) pkt.push_back(8'($urandom));
    pkt[0] = {ver, 4'(ihl)};
    pkt[2] = 8'(tot >> 8);
    pkt[3] = 8'(tot);
    pkt[9] = proto;
    pkt[10] = 8'h00;
    pkt[11] = 8'h00;
    sum = 0;
    for (int i = 0; i < hl; i += 2) sum += 32'({pkt[i], pkt[i+1]});
    while ((sum >> 16) != 0) sum = (sum & 32'hFFFF) + (sum >> 16);
    pkt[10] = ~sum[15:8];
    pkt[11] = ~sum[7:0];
    if (corrupt) pkt[10] = pkt[10] ^ 8'h01;
  endtask

  function automatic bit model_accepts(input bit csum_en);
    logic [7:0] b0;
    int hl, tot;
    int unsigned sum;
    b0 = pkt[0];
    hl = 4 * int'(b0[3:0]);
    tot = int'({pkt[2], pkt[3]});
    sum = 0;
    for (int i = 0; i + 1 < hl; i += 2) sum += 32'({pkt[i], pkt[i+1]});
    while ((sum >> 16) != 0) sum = (sum & 32'hFFFF) + (sum >> 16);
    return (b0[7:4] == 4'd4) && (hl >= 20) && (tot >= hl + 8) && (pkt[9] == 8'd17) &&
           (!csum_en || sum == 32'hFFFF);
  endfunction

  task automatic expect_pkt();
    logic [7:0] b0;
    int hl, tot;
    b0 = pkt[0];
    hl = 4 * int'(b0[3:0]);
    tot = int'({pkt[2], pkt[3]});
    if (model_accepts(1'b1)) begin
      for (int i = hl; i < tot; i++) exp_q.push_back({(i == tot - 1), pkt[i]});
      exp_src = {pkt[12], pkt[13], pkt[14], pkt[15]};
      exp_dst = {pkt[16], pkt[17], pkt[18], pkt[19]};
      exp_tot = 16'(tot);
    end else if (exp_drops < 65535) begin
      exp_drops++;
    end
  endtask

  task automatic send_bytes(input int n, input int max_gap);
    logic [7:0] b0;
    int hl, guard;
    bit acc;
    b0 = pkt[0];
    hl = (b0[3:0] < 4'd5) ? 20 : 4 * int'(b0[3:0]);
    for (int i = 0; i < n; i++) begin
      ip_data_in = pkt[i];
      ip_valid_in = 1'b1;
      guard = 0;
      acc = 1'b0;
      while (!acc) begin
        @(negedge clk);
        acc = ip_ready_out;
        if (acc && i == hl - 1) hdr_acc_cyc = cyc;
        @(posedge clk); #1;
        guard++;
        if (!acc && guard > 50) begin
          n_checks++; n_fail++;
          $display("FAIL input_accept: byte %0d not accepted after %0d cycles (required <= 50)", i, guard);
          ip_valid_in = 1'b0;
          return;
        end
      end
      ip_valid_in = 1'b0;
      if (max_gap > 0) begin
        repeat ($urandom_range(0, max_gap)) begin
          @(posedge clk); #1;
        end
      end
    end
    ip_valid_in = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int i;
    for (i = 0; i < 500; i++) begin
      @(negedge clk);
      if (rx_q.size() >= exp_q.size() && !data_valid_out) break;
    end
    if (i == 500) begin
      n_checks++; n_fail++;
      $display("FAIL %s_drain: got %0d bytes after 500 cycles, required %0d", name, rx_q.size(), exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ip_valid_in = 1'b0; ip_data_in = '0; nc_valid_in = 1'b0; nc_data_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (ip_ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", ip_ready_out); end
    n_checks++; if (data_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", data_valid_out); end
    n_checks++; if ({data_out, data_last_out} !== 9'd0) begin n_fail++; $display("FAIL reset_data: got %h/%b required 0", data_out, data_last_out); end
    n_checks++; if ({hdr_valid, drop_pulse} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b%b required 00", hdr_valid, drop_pulse); end
    n_checks++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL reset_drop_count: got %0d required 0", drop_count); end
    n_checks++; if ({src_ip, dst_ip, ip_total_length} !== 80'd0) begin n_fail++; $display("FAIL reset_fields: got %h %h %h required 0", src_ip, dst_ip, ip_total_length); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_valid_udp();
    int hv0;
    ready_mode = 0;
    hv0 = hv_cnt;
    build_pkt(5, 16, 8'd17, 4'd4, 1'b0);
    expect_pkt();
    send_bytes(36, 0);
    wait_drain("valid_udp");
    n_checks++; if (rx_q.size() != 16) begin n_fail++; $display("FAIL valid_udp_count: got %0d bytes required 16", rx_q.size()); end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL valid_udp_byte[%0d]: got %h required %h", i, rx_q[i], exp_q[i]); end
    end
    n_checks++; if (hv_cnt - hv0 != 1) begin n_fail++; $display("FAIL valid_udp_hdr_valid: got %0d pulses required 1", hv_cnt - hv0); end
    n_checks++; if (hv_cyc != hdr_acc_cyc + 1) begin n_fail++; $display("FAIL valid_udp_hdr_timing: got cycle %0d required %0d", hv_cyc, hdr_acc_cyc + 1); end
    n_checks++; if (src_ip !== exp_src) begin n_fail++; $display("FAIL valid_udp_src: got %h required %h", src_ip, exp_src); end
    n_checks++; if (dst_ip !== exp_dst) begin n_fail++; $display("FAIL valid_udp_dst: got %h required %h", dst_ip, exp_dst); end
    n_checks++; if (ip_total_length !== 16'd36) begin n_fail++; $display("FAIL valid_udp_len: got %0d required 36", ip_total_length); end
    n_checks++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL valid_udp_drops: got %0d required 0", drop_count); end
    rx_q.delete(); exp_q.delete();
  endtask

  task automatic test_bad_csum();
    int dp0;
    dp0 = dp_cnt;
    build_pkt(5, 16, 8'd17, 4'd4, 1'b1);
    expect_pkt();
    send_bytes(36, 0);
    build_pkt(5, 16, 8'd17, 4'd4, 1'b0);
    expect_pkt();
    send_bytes(36, 0);
    wait_drain("bad_csum");
    n_checks++; if (dp_cnt - dp0 != 1) begin n_fail++; $display("FAIL bad_csum_pulse: got %0d pulses required 1", dp_cnt - dp0); end
    n_checks++; if (drop_count !== 16'd1) begin n_fail++; $display("FAIL bad_csum_count: got %0d required 1", drop_count); end
    n_checks++; if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bad_csum_len: got %0d bytes required %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bad_csum_next_byte[%0d]: got %h required %h", i, rx_q[i], exp_q[i]); end
    end
    rx_q.delete(); exp_q.delete();
  endtask

  task automatic test_tcp();
    build_pkt(5, 16, 8'd6, 4'd4, 1'b0);
    expect_pkt();
    send_bytes(36, 0);
    wait_drain("tcp");
    n_checks++; if (drop_count !== 16'(exp_drops)) begin n_fail++; $display("FAIL tcp_drop_count: got %0d required %0d", drop_count, exp_drops); end
    n_checks++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL tcp_output: got %0d bytes required 0", rx_q.size()); end
    rx_q.delete(); exp_q.delete();
  endtask

  task automatic test_nocsum();
    build_pkt(5, 16, 8'd17, 4'd4, 1'b1);
    if (model_accepts(1'b0)) for (int i = 20; i < 36; i++) nc_exp_q.push_back({(i == 35), pkt[i]});
    for (int i = 0; i < 36; i++) begin
      nc_data_in = pkt[i];
      nc_valid_in = 1'b1;
      @(negedge clk);
      if (!nc_ready_out) begin n_checks++; n_fail++; $display("FAIL nocsum_ready: byte %0d got ready 0 required 1", i); end
      @(posedge clk); #1;
    end
    nc_valid_in = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (nc_rx_q.size() != 16) begin n_fail++; $display("FAIL nocsum_count: got %0d bytes required 16", nc_rx_q.size()); end
    for (int i = 0; i < nc_rx_q.size() && i < nc_exp_q.size(); i++) begin
      n_checks++;
      if (nc_rx_q[i] !== nc_exp_q[i]) begin n_fail++; $display("FAIL nocsum_byte[%0d]: got %h required %h", i, nc_rx_q[i], nc_exp_q[i]); end
    end
    n_checks++; if (nc_hv_cnt != 1 || nc_dp_cnt != 0 || nc_dc !== 16'd0) begin n_fail++; $display("FAIL nocsum_pulses: got hv %0d dp %0d cnt %0d required 1 0 0", nc_hv_cnt, nc_dp_cnt, nc_dc); end
    n_checks++; if ({nc_src, nc_dst, nc_tot} !== {pkt[12], pkt[13], pkt[14], pkt[15], pkt[16], pkt[17], pkt[18], pkt[19], 16'd36}) begin
      n_fail++; $display("FAIL nocsum_fields: got %h %h %0d", nc_src, nc_dst, nc_tot);
    end
    nc_rx_q.delete(); nc_exp_q.delete();
  endtask

  task automatic test_options();
    logic [8:0] first;
    build_pkt(6, 16, 8'd17, 4'd4, 1'b0);
    expect_pkt();
    send_bytes(40, 0);
    wait_drain("options");
    n_checks++; if (rx_q.size() != 16) begin n_fail++; $display("FAIL options_count: got %0d bytes required 16", rx_q.size()); end
    if (rx_q.size() > 0) begin
      first = rx_q[0];
      n_checks++; if (first[7:0] !== pkt[24]) begin n_fail++; $display("FAIL options_first: got %h required %h", first[7:0], pkt[24]); end
    end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL options_byte[%0d]: got %h required %h", i, rx_q[i], exp_q[i]); end
    end
    n_checks++; if (ip_total_length !== 16'd40) begin n_fail++; $display("FAIL options_len: got %0d required 40", ip_total_length); end
    rx_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int ov0, bp0, hd0;
    ready_mode = 1;
    ov0 = overlap; bp0 = bp_viol; hd0 = hold_viol;
    for (int k = 0; k < 3; k++) begin
      build_pkt(5 + (k % 2), 12 + k, 8'd17, 4'd4, 1'b0);
      expect_pkt();
      send_bytes(pkt.size(), 0);
    end
    wait_drain("b2b");
    n_checks++; if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d bytes required %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_byte[%0d]: got %h required %h", i, rx_q[i], exp_q[i]); end
    end
    n_checks++; if (bp_viol != bp0) begin n_fail++; $display("FAIL b2b_backpressure: got %0d ready-while-full cycles required 0", bp_viol - bp0); end
    n_checks++; if (hold_viol != hd0) begin n_fail++; $display("FAIL b2b_hold: got %0d unstable stalled cycles required 0", hold_viol - hd0); end
    n_checks++; if (overlap <= ov0) begin n_fail++; $display("FAIL b2b_overlap: got %0d header beats under pending last byte required > 0", overlap - ov0); end
    rx_q.delete(); exp_q.delete();
    ready_mode = 0;
  endtask

  task automatic test_random();
    int hv0, acc_n, bp0, hd0, r;
    ready_mode = 2;
    hv0 = hv_cnt; acc_n = 0; bp0 = bp_viol; hd0 = hold_viol;
    for (int k = 0; k < 14; k++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: build_pkt($urandom_range(5, 7), $urandom_range(8, 30), 8'd17, 4'd4, 1'b1);
        1: build_pkt($urandom_range(5, 7), $urandom_range(8, 30), 8'd6, 4'd4, 1'b0);
        2: build_pkt($urandom_range(5, 7), $urandom_range(8, 30), 8'd17, 4'd6, 1'b0);
        3: build_pkt($urandom_range(5, 7), 4, 8'd17, 4'd4, 1'b0);
        default: build_pkt($urandom_range(5, 7), $urandom_range(8, 30), 8'd17, 4'd4, 1'b0);
      endcase
      if (model_accepts(1'b1)) acc_n++;
      expect_pkt();
      send_bytes(pkt.size(), 2);
    end
    wait_drain("random");
    n_checks++; if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL random_count: got %0d bytes required %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL random_byte[%0d]: got %h required %h", i, rx_q[i], exp_q[i]); end
    end
    n_checks++; if (drop_count !== 16'(exp_drops)) begin n_fail++; $display("FAIL random_drops: got %0d required %0d", drop_count, exp_drops); end
    n_checks++; if (hv_cnt - hv0 != acc_n) begin n_fail++; $display("FAIL random_hdr_valid: got %0d required %0d", hv_cnt - hv0, acc_n); end
    n_checks++; if (bp_viol != bp0 || hold_viol != hd0) begin n_fail++; $display("FAIL random_backpressure: got %0d/%0d violations required 0", bp_viol - bp0, hold_viol - hd0); end
    rx_q.delete(); exp_q.delete();
    ready_mode = 0;
  endtask

  task automatic test_mid_reset();
    ready_mode = 0;
    build_pkt(5, 16, 8'd17, 4'd4, 1'b0);
    send_bytes(26, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (data_valid_out !== 1'b0 || data_last_out !== 1'b0) begin n_fail++; $display("FAIL midrst_output: got valid %b last %b required 0 0", data_valid_out, data_last_out); end
    n_checks++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL midrst_drop_count: got %0d required 0", drop_count); end
    n_checks++; if (ip_ready_out !== 1'b1 || hdr_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl: got ready %b hv %b required 1 0", ip_ready_out, hdr_valid); end
    n_checks++; if ({src_ip, dst_ip, ip_total_length} !== 80'd0) begin n_fail++; $display("FAIL midrst_fields: got %h %h %h required 0", src_ip, dst_ip, ip_total_length); end
    @(posedge clk); #1;
    rx_q.delete(); exp_q.delete(); exp_drops = 0;
    build_pkt(5, 20, 8'd17, 4'd4, 1'b0);
    expect_pkt();
    send_bytes(pkt.size(), 0);
    wait_drain("midrst");
    n_checks++; if (rx_q.size() != 20) begin n_fail++; $display("FAIL midrst_count: got %0d bytes required 20", rx_q.size()); end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL midrst_byte[%0d]: got %h required %h", i, rx_q[i], exp_q[i]); end
    end
    n_checks++; if (src_ip !== exp_src || dst_ip !== exp_dst) begin n_fail++; $display("FAIL midrst_addr: got %h %h required %h %h", src_ip, dst_ip, exp_src, exp_dst); end
    rx_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_valid_udp();
    test_bad_csum();
    test_tcp();
    test_nocsum();
    test_options();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ipv4_header_stripper.md
# ipv4_header_stripper

Upstream neighbour of the UDP parsing stage. Accepts a raw IPv4 packet as a byte stream, parses and validates the IPv4 header, then discards the header and its options. For valid UDP packets it forwards the IP payload (the UDP datagram) downstream with a valid/ready handshake and a last-byte marker; every other packet is consumed and dropped. Header fields are latched for the rest of the design.

## Interface
Parameters:
- CHECK_CSUM, default 1: when 1, a header checksum failure drops the packet; when 0, the checksum is ignored.

Ports:
- clk  in  1  single clock
- rst_n  in  1  synchronous reset, active-low
- ip_data_in  in  8  IPv4 packet byte, network byte order
- ip_valid_in  in  1  ip_data_in valid
- ip_ready_out  out  1  stage can accept a byte
- data_out  out  8  forwarded UDP datagram byte
- data_valid_out  out  1  data_out valid
- data_last_out  out  1  final byte of datagram, qualified by data_valid_out
- ready_in  in  1  downstream accepts data_out
- src_ip  out  32  latched source address
- dst_ip  out  32  latched destination address
- ip_total_length  out  16  latched total length
- hdr_valid  out  1  one-cycle pulse: header accepted, forwarding begins
- drop_pulse  out  1  one-cycle pulse: packet rejected
- drop_count  out  16  saturating count of rejected packets

## Operation
- An input beat transfers when ip_valid_in && ip_ready_out. An output beat transfers when data_valid_out && ready_in.
- States:
  - HDR (reset state)
  - FWD
  - DROP
- byte_cnt (16 bit) counts accepted bytes from the packet start. It resets to 0 on every return to HDR.
- HDR:
  - ip_ready_out = 1.
  - Captures bytes 0 (version/IHL), 2–3 (total_length), 9 (protocol), 12–15 (src), and 16–19 (dst). Option bytes are consumed and discarded.
  - hdr_len = IHL*4, taken from byte 0.
- Checksum:
  - Ones'-complement sum of 16-bit big-endian words over all hdr_len bytes, including options and the checksum field.
  - Accumulated with end-around carry as each odd byte arrives.
  - Passes if the folded sum is 16'hFFFF.
- Decision on acceptance of byte hdr_len-1 (combinational on that beat). Reject if any of:
  - version != 4
  - IHL < 5
  - total_length < hdr_len + 8
  - protocol != 17
  - checksum fails and CHECK_CSUM = 1
- Accept: move to FWD. Latch src_ip, dst_ip and ip_total_length. Pulse hdr_valid next cycle.
- Reject: move to DROP. Pulse drop_pulse next cycle. Increment drop_count, saturating at 16'hFFFF.
- FWD:
  - Single-entry output register.
  - ip_ready_out = !data_valid_out || ready_in.
  - Each accepted byte loads data_out. data_last_out is set when byte_cnt == total_length-1.
  - After accepting that byte, return to HDR. The output register may still hold the last byte; the next header's bytes are accepted concurrently.
- DROP:
  - ip_ready_out = 1, no output.
  - Consume until byte_cnt == total_length-1, then HDR.
- The length fields are trusted; there is no input-side last signal.
- Reset values: all outputs 0 except ip_ready_out = 1. State = HDR.

## Timing
- Forwarding latency: 1 cycle from input acceptance to data_valid_out.
- Sustained throughput: 1 byte/cycle with ready_in held high.
- Backpressure: with data_valid_out = 1 and ready_in = 0, ip_ready_out = 0 and data_out/data_last_out hold stable.
- hdr_valid and drop_pulse fire exactly one cycle after the final header beat.
- Header fields are stable from hdr_valid until the next accepted header.
- A reset asserted mid-packet:
  - takes effect on the next clk edge;
  - discards the output register contents;
  - leaves drop_count at 0.
- The first byte after reset is treated as byte 0 of a new packet.
- An input stall (ip_valid_in = 0) in any state holds all counters and state.

## Test plan
- Valid UDP packet: IHL 5, total_length 36, proto 17, correct checksum, ready_in = 1.
  -> 16 bytes out equal to input bytes 20..35.
  -> data_last_out on the 16th byte only.
  -> hdr_valid one pulse; src_ip/dst_ip match bytes 12–19.
- Same packet with the checksum byte flipped.
  -> No output; drop_pulse once; drop_count = 1.
  -> All 36 bytes consumed; the following valid packet is forwarded normally.
- Protocol = 6 (TCP), valid checksum.
  -> Dropped, drop_count increments.
  -> With CHECK_CSUM = 0 and a bad checksum on a UDP packet: forwarded.
- IHL = 6, total_length 40.
  -> 4 option bytes stripped; the first data_out equals input byte 24; 16 bytes forwarded.
- Back-to-back packets with ready_in toggling 1,0,1,0.
  -> No loss or duplication; ip_ready_out = 0 whenever output full and ready_in = 0.
  -> The second header is parsed while the first packet's last byte awaits ready_in.
- rst_n low for 1 cycle at payload byte 5.
  -> All outputs return to reset values the following cycle; a fresh packet is parsed from byte 0 correctly.
